// File: rtl/wb_port_arbiter.sv
// ============================================================================
// wb_port_arbiter : round-robin arbiter for two register-file write ports
//   Optional conflict counter enabled by macro WB_CONFLICT_CNT_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module wb_port_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 32,
  parameter int AW   = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wb_stall,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_rd,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic               reg_write,
  output logic [AW-1:0]      regd,
  output logic [DW-1:0]      write_data,
  output logic               reg_write2,
  output logic [AW-1:0]      regd2,
  output logic [DW-1:0]      write_data2
`ifdef WB_CONFLICT_CNT_EN
  ,
  output logic [15:0]        conflict_cnt
`endif
);

  localparam int c_PW = (NREQ > 2) ? $clog2(NREQ) : 1;

  function automatic logic [c_PW-1:0] wrap_idx(input logic [c_PW-1:0] base,
                                               input int unsigned     off);
    logic [c_PW:0] s;
    s = {1'b0, base} + (c_PW+1)'(off);
    if (s >= (c_PW+1)'(NREQ)) s = s - (c_PW+1)'(NREQ);
    return s[c_PW-1:0];
  endfunction

  logic [c_PW-1:0] ptr_q, ptr_d;
  logic            reg_write_q, reg_write2_q;
  logic [AW-1:0]   regd_q, regd2_q;
  logic [DW-1:0]   write_data_q, write_data2_q;

  // Requesters rotated into scan order starting at the round-robin pointer.
  logic [c_PW-1:0] w_idx  [NREQ];
  logic [AW-1:0]   w_rd   [NREQ];
  logic [DW-1:0]   w_data [NREQ];
  logic [NREQ-1:0] w_vld;

  for (genvar k = 0; k < NREQ; k++) begin : g_scan
    assign w_idx[k]  = wrap_idx(ptr_q, k);
    assign w_rd[k]   = req_rd[w_idx[k]*AW +: AW];
    assign w_data[k] = req_data[w_idx[k]*DW +: DW];
    assign w_vld[k]  = req_valid[w_idx[k]];
  end

  logic [NREQ-1:0] w_ready;
  logic            w_p1, w_p2, w_conflict;
  logic [AW-1:0]   w_p1_rd, w_p2_rd;
  logic [DW-1:0]   w_p1_data, w_p2_data;
  logic [c_PW-1:0] w_last;

  always_comb begin
    w_ready    = '0;
    w_p1       = 1'b0;
    w_p2       = 1'b0;
    w_conflict = 1'b0;
    w_p1_rd    = '0;
    w_p2_rd    = '0;
    w_p1_data  = '0;
    w_p2_data  = '0;
    w_last     = ptr_q;
    for (int k = 0; k < NREQ; k++) begin
      if (!rst && !wb_stall && w_vld[k]) begin
        if (w_rd[k] == '0) begin
          w_ready[w_idx[k]] = 1'b1;
        end else if (!w_p1) begin
          w_p1              = 1'b1;
          w_p1_rd           = w_rd[k];
          w_p1_data         = w_data[k];
          w_last            = w_idx[k];
          w_ready[w_idx[k]] = 1'b1;
        end else if (!w_p2 && (w_rd[k] != w_p1_rd)) begin
          w_p2              = 1'b1;
          w_p2_rd           = w_rd[k];
          w_p2_data         = w_data[k];
          w_last            = w_idx[k];
          w_ready[w_idx[k]] = 1'b1;
        end else if (!w_p2) begin
          // Port 2 still free, so this denial is purely a same-rd conflict.
          w_conflict = 1'b1;
        end
      end
    end
  end

  assign ptr_d     = w_p1 ? wrap_idx(w_last, 1) : ptr_q;
  assign req_ready = w_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q         <= '0;
      reg_write_q   <= 1'b0;
      reg_write2_q  <= 1'b0;
      regd_q        <= '0;
      regd2_q       <= '0;
      write_data_q  <= '0;
      write_data2_q <= '0;
    end else begin
      ptr_q        <= ptr_d;
      reg_write_q  <= w_p1;
      reg_write2_q <= w_p2;
      if (w_p1) begin
        regd_q       <= w_p1_rd;
        write_data_q <= w_p1_data;
      end
      if (w_p2) begin
        regd2_q       <= w_p2_rd;
        write_data2_q <= w_p2_data;
      end
    end
  end

  assign reg_write   = reg_write_q;
  assign reg_write2  = reg_write2_q;
  assign regd        = regd_q;
  assign regd2       = regd2_q;
  assign write_data  = write_data_q;
  assign write_data2 = write_data2_q;

`ifdef WB_CONFLICT_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  assign cnt_d = (w_conflict && (cnt_q != 16'hFFFF)) ? cnt_q + 16'd1 : cnt_q;

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign conflict_cnt = cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
// ============================================================================
// tb_wb_port_arbiter : directed vector bench for wb_port_arbiter (NREQ=4)
//   Counter checks active when WB_CONFLICT_CNT_EN is defined.         Rev 1.0
// ============================================================================
`default_nettype none

module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_stall;
  logic [3:0]  req_valid;
  logic [19:0] req_rd;
  logic [127:0] req_data;
  logic [3:0]  req_ready;
  logic        reg_write, reg_write2;
  logic [4:0]  regd, regd2;
  logic [31:0] write_data, write_data2;
`ifdef WB_CONFLICT_CNT_EN
  logic [15:0] conflict_cnt;
`endif

  always #5 clk = ~clk;

  // Requester i always carries data 0xA+i.
  assign req_data = {32'hD, 32'hC, 32'hB, 32'hA};

  wb_port_arbiter #(.NREQ(4), .DW(32), .AW(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .wb_stall    (wb_stall),
    .req_valid   (req_valid),
    .req_rd      (req_rd),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .reg_write   (reg_write),
    .regd        (regd),
    .write_data  (write_data),
    .reg_write2  (reg_write2),
    .regd2       (regd2),
    .write_data2 (write_data2)
`ifdef WB_CONFLICT_CNT_EN
    ,
    .conflict_cnt(conflict_cnt)
`endif
  );

  typedef struct {
    logic        rst;
    logic        stall;
    logic [3:0]  valid;
    logic [19:0] rd;
    logic [3:0]  ready;
    logic        we;
    logic [4:0]  regd;
    logic [31:0] wd;
    logic        we2;
    logic [4:0]  regd2;
    logic [31:0] wd2;
    logic [15:0] cnt;
  } vec_t;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  vec_t tv[19];

  initial begin
    logic [3:0] seen;
    tv[0]  = '{1'b1, 1'b0, 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, 4'b0000, 1'b0, 5'd0,  32'h0, 1'b0, 5'd0,  32'h0, 16'd0};
    tv[1]  = '{1'b0, 1'b0, 4'b0011, {5'd0, 5'd0, 5'd7, 5'd3}, 4'b0011, 1'b1, 5'd3,  32'hA, 1'b1, 5'd7,  32'hB, 16'd0};
    tv[2]  = '{1'b0, 1'b0, 4'b1111, {5'd6, 5'd4, 5'd2, 5'd1}, 4'b1100, 1'b1, 5'd4,  32'hC, 1'b1, 5'd6,  32'hD, 16'd0};
    tv[3]  = '{1'b0, 1'b0, 4'b0011, {5'd0, 5'd0, 5'd5, 5'd5}, 4'b0001, 1'b1, 5'd5,  32'hA, 1'b0, 5'd0,  32'h0, 16'd1};
    tv[4]  = '{1'b0, 1'b0, 4'b0010, {5'd0, 5'd0, 5'd5, 5'd5}, 4'b0010, 1'b1, 5'd5,  32'hB, 1'b0, 5'd0,  32'h0, 16'd1};
    tv[5]  = '{1'b0, 1'b0, 4'b1100, {5'd9, 5'd0, 5'd0, 5'd0}, 4'b1100, 1'b1, 5'd9,  32'hD, 1'b0, 5'd0,  32'h0, 16'd1};
    tv[6]  = '{1'b0, 1'b0, 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, 4'b0011, 1'b1, 5'd1,  32'hA, 1'b1, 5'd2,  32'hB, 16'd1};
    tv[7]  = '{1'b0, 1'b0, 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, 4'b1100, 1'b1, 5'd3,  32'hC, 1'b1, 5'd4,  32'hD, 16'd1};
    tv[8]  = '{1'b0, 1'b0, 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, 4'b0011, 1'b1, 5'd1,  32'hA, 1'b1, 5'd2,  32'hB, 16'd1};
    tv[9]  = '{1'b0, 1'b1, 4'b0110, {5'd0, 5'd8, 5'd6, 5'd0}, 4'b0000, 1'b0, 5'd0,  32'h0, 1'b0, 5'd0,  32'h0, 16'd1};
    tv[10] = '{1'b0, 1'b0, 4'b0110, {5'd0, 5'd8, 5'd6, 5'd0}, 4'b0110, 1'b1, 5'd8,  32'hC, 1'b1, 5'd6,  32'hB, 16'd1};
    tv[11] = '{1'b0, 1'b1, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd0}, 4'b0000, 1'b0, 5'd0,  32'h0, 1'b0, 5'd0,  32'h0, 16'd1};
    tv[12] = '{1'b0, 1'b0, 4'b0000, {5'd0, 5'd0, 5'd0, 5'd0}, 4'b0000, 1'b0, 5'd0,  32'h0, 1'b0, 5'd0,  32'h0, 16'd1};
    tv[13] = '{1'b0, 1'b0, 4'b0100, {5'd0, 5'd0, 5'd0, 5'd0}, 4'b0100, 1'b0, 5'd0,  32'h0, 1'b0, 5'd0,  32'h0, 16'd1};
    tv[14] = '{1'b0, 1'b0, 4'b0111, {5'd0, 5'd10, 5'd2, 5'd1}, 4'b0101, 1'b1, 5'd10, 32'hC, 1'b1, 5'd1,  32'hA, 16'd1};
    tv[15] = '{1'b0, 1'b0, 4'b1111, {5'd12, 5'd7, 5'd7, 5'd7}, 4'b1010, 1'b1, 5'd7,  32'hB, 1'b1, 5'd12, 32'hD, 16'd2};
    tv[16] = '{1'b0, 1'b0, 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, 4'b0011, 1'b1, 5'd1,  32'hA, 1'b1, 5'd2,  32'hB, 16'd2};
    tv[17] = '{1'b1, 1'b0, 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, 4'b0000, 1'b0, 5'd0,  32'h0, 1'b0, 5'd0,  32'h0, 16'd0};
    tv[18] = '{1'b0, 1'b0, 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, 4'b0011, 1'b1, 5'd1,  32'hA, 1'b1, 5'd2,  32'hB, 16'd0};

    rst = 1'b1; wb_stall = 1'b0; req_valid = '0; req_rd = '0;
    @(posedge clk); #1;

    for (int i = 0; i < 19; i++) begin
      rst = tv[i].rst; wb_stall = tv[i].stall;
      req_valid = tv[i].valid; req_rd = tv[i].rd;
      #1;
      chk($sformatf("v%0d ready", i), 64'(req_ready), 64'(tv[i].ready));
      @(posedge clk); #1;
      chk($sformatf("v%0d reg_write", i), 64'(reg_write), 64'(tv[i].we));
      chk($sformatf("v%0d reg_write2", i), 64'(reg_write2), 64'(tv[i].we2));
      if (tv[i].we || tv[i].rst) begin
        chk($sformatf("v%0d regd", i), 64'(regd), 64'(tv[i].regd));
        chk($sformatf("v%0d write_data", i), 64'(write_data), 64'(tv[i].wd));
      end
      if (tv[i].we2 || tv[i].rst) begin
        chk($sformatf("v%0d regd2", i), 64'(regd2), 64'(tv[i].regd2));
        chk($sformatf("v%0d write_data2", i), 64'(write_data2), 64'(tv[i].wd2));
      end
`ifdef WB_CONFLICT_CNT_EN
      chk($sformatf("v%0d conflict_cnt", i), 64'(conflict_cnt), 64'(tv[i].cnt));
`endif
    end

    // All four target rd=5 from ptr=2: one grant per cycle, each drops once served,
    // and every requester must be served within NREQ cycles.
    rst = 1'b0; wb_stall = 1'b0;
    req_rd = {5'd5, 5'd5, 5'd5, 5'd5};
    req_valid = 4'b1111;
    seen = '0;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("starve c%0d one-ready", c), 64'($countones(req_ready)), 64'd1);
      if (c == 0) chk("starve c0 ptr-order", 64'(req_ready), 64'b0100);
      seen = seen | req_ready;
      @(posedge clk); #1;
      req_valid = req_valid & ~seen;
      chk($sformatf("starve c%0d reg_write", c), 64'(reg_write), 64'd1);
      chk($sformatf("starve c%0d regd", c), 64'(regd), 64'd5);
      chk($sformatf("starve c%0d reg_write2", c), 64'(reg_write2), 64'd0);
    end
    chk("starve all granted", 64'(seen), 64'b1111);
`ifdef WB_CONFLICT_CNT_EN
    chk("starve conflict_cnt", 64'(conflict_cnt), 64'd3);
`endif
    req_valid = '0;
    @(posedge clk); #1;
    chk("idle reg_write", 64'(reg_write), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the register file's two write ports between NREQ writeback requesters (ALU0, ALU1, load unit, mul/div).
- Each cycle, grants up to two requests in round-robin order and never grants two writes to the same rd.
- Drives registered write enables, addresses and data straight into the register file write ports.
- Port 2 corresponds to the register file's priority port (reg_write2/regd2/write_data2).

Parameters:
- NREQ, 4, number of writeback requesters (2..8)
- DW, 32, write data width
- AW, 5, register address width

Ports:
- clk  input  1  clock
- rst  input  1  reset; synchronous, active-high
- wb_stall  input  1  when high, grants nothing this cycle
- req_valid  input  NREQ  per-requester write request
- req_rd  input  NREQ*AW  packed destination registers; requester i at bits [i*AW +: AW]
- req_data  input  NREQ*DW  packed write data; requester i at bits [i*DW +: DW]
- req_ready  output  NREQ  combinational grant; handshake = valid & ready
- reg_write  output  1  write port 1 enable (registered)
- regd  output  AW  write port 1 address
- write_data  output  DW  write port 1 data
- reg_write2  output  1  write port 2 enable (registered)
- regd2  output  AW  write port 2 address
- write_data2  output  DW  write port 2 data

Behaviour:
- Reset (sync, rst=1 at posedge):
  - reg_write, reg_write2, regd, regd2, write_data, write_data2 all 0.
  - Round-robin pointer ptr = 0.
  - Requests pending during reset are not acknowledged; requesters must re-present them.
- Requester contract: hold valid, rd and data stable until req_ready is seen.
- Arbitration, combinational each cycle with wb_stall=0:
  - Scan i = ptr, ptr+1, ... modulo NREQ.
  - Valid request with rd==0: req_ready=1 the same cycle, consumes no port, causes no write (discard).
  - First valid request with rd!=0 gets port 1 (regd/write_data).
  - Next valid request with rd!=0 and rd != port-1 rd gets port 2.
  - Any further valid request, including a same-rd conflicting one, gets req_ready=0 and waits.
- wb_stall=1:
  - All req_ready = 0, including rd==0 requests.
  - Next cycle reg_write = reg_write2 = 0.
  - ptr unchanged.
- Latency: a grant in cycle N appears on the write ports at posedge N+1 and lands in the register file at posedge N+2.
- Ungranted port: enable 0 next cycle; addr/data hold their previous values (don't-care).
- ptr update:
  - If any port granted: ptr <= (index of last port-granted requester + 1) mod NREQ.
  - Otherwise (no grant, or only rd==0 discards): unchanged.
- Guarantees:
  - regd != regd2 whenever both enables are high.
  - Writes to x0 are never issued.
  - Starvation-free: a continuously valid request is granted within NREQ cycles when wb_stall=0.

Optional Feature:
- Macro: WB_CONFLICT_CNT_EN.
- Defined:
  - Adds output conflict_cnt [15:0].
  - Counts cycles in which at least one valid rd!=0 request was denied only because of a same-rd conflict (not port exhaustion, not stall).
  - Saturates at 16'hFFFF; cleared by rst.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset check: assert rst with req_valid=4'b1111 -> req_ready=0; next cycle all outputs 0; after release, ptr=0 so req0 is granted first.
- Two-way grant:
  - Stimulus: req0 rd=3 data=32'hA, req1 rd=7 data=32'hB, ptr=0.
  - Response: req_ready=4'b0011; next cycle reg_write=1 regd=3 write_data=A, reg_write2=1 regd2=7 write_data2=B; ptr=2.
- Same-rd conflict:
  - Stimulus: req0 and req1 both rd=5, ptr=0.
  - Response: cycle 1 grants only req0 (ready=4'b0001, reg_write2=0 next cycle); cycle 2 grants req1 on port 1; conflict_cnt=1 when WB_CONFLICT_CNT_EN.
- x0 discard:
  - Stimulus: req2 rd=0, req3 rd=9.
  - Response: ready=4'b1100 same cycle; next cycle reg_write=1 regd=9, reg_write2=0.
- Fairness: all four valid, distinct rds, held 2 cycles -> cycle 1 grants req0/req1, cycle 2 grants req2/req3; ptr returns to 0.
- Stall mid-stream: wb_stall=1 with req_valid=4'b0110 -> ready=0, next-cycle enables 0, ptr unchanged; after stall drops, req1/req2 are granted.
